snoopy_bus_arbiter: RTL and testbench
=====================================

Name: snoopy_bus_arbiter

Overview:
Shares one memory-side system bus between NREQ cache clients, for example the I-side and D-side snoopy read-only caches.
Read and write requests are granted round-robin and forwarded one at a time.
Each completed write triggers an invalidate broadcast to the client caches. The write is acknowledged only after every targeted cache has returned inv_ready, so all copies are coherent before the writer proceeds.

Parameters:
NREQ, 2, number of requesting clients (at least 2)
ADDR_WIDTH, 32, address width
WIDTH, 128, data line width
MASKW, WIDTH/8, byte-mask width

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
req_rw_valid  in  NREQ  per-client request valid; held until that client's req_rw_ready
req_rw_ready  out  NREQ  per-client one-cycle completion pulse
req_rw_addr  in  NREQ*ADDR_WIDTH  per-client address
req_rw_we  in  NREQ  per-client write enable
req_w_mask  in  NREQ*MASKW  per-client write byte mask
req_w_data  in  NREQ*WIDTH  per-client write data
req_w_ce  in  NREQ  per-client write chip-enable
req_r_data  out  WIDTH  read data, shared by all clients; valid while req_rw_ready is high
req_inv_valid  out  NREQ  per-client invalidate request
req_inv_addr  out  ADDR_WIDTH  invalidate address, shared by all clients
req_inv_ready  in  NREQ  per-client invalidate acknowledge
mem_rw_valid  out  1  memory request valid
mem_rw_ready  in  1  memory completion pulse; mem_r_data valid in the same cycle
mem_rw_addr  out  ADDR_WIDTH  memory address
mem_rw_we  out  1  memory write enable
mem_w_mask  out  MASKW  memory write byte mask
mem_w_data  out  WIDTH  memory write data
mem_w_ce  out  1  memory write chip-enable
mem_r_data  in  WIDTH  memory read data

Behaviour:
- Reset values: state ARB_IDLE; all outputs 0; pending mask 0; round-robin pointer 0, so client 0 has top priority after reset. Reset mid-transaction abandons it; no ready or inv is issued afterwards.
- ARB_IDLE:
  - If any req_rw_valid is set, grant the first requester at or after (last_grant+1) mod NREQ.
  - Latch that client's addr, we, mask, data and ce into a request register; go to ARB_MEM.
  - Non-granted requests wait; they are never dropped.
- ARB_MEM:
  - mem_rw_valid=1; mem_* are driven from the latched request only.
  - On mem_rw_ready with a read: latch mem_r_data and go to ARB_RESP.
  - On mem_rw_ready with a write: load pending with the target mask, then:
    - non-zero pending: go to ARB_INV;
    - zero pending: go directly to ARB_RESP.
  - mem_rw_valid drops in the cycle after mem_rw_ready.
- ARB_INV:
  - req_inv_valid[i] = pending[i]; req_inv_addr = latched address, held stable for the whole state.
  - req_inv_ready[i] clears pending[i] at the clock edge, so inv_valid[i] falls the next cycle and the client does not re-trigger.
  - req_inv_ready on a non-pending client is ignored.
  - Multiple acknowledges in the same cycle are all accepted.
  - When pending==0, go to ARB_RESP.
  - No timeout.
- ARB_RESP:
  - req_rw_ready[grant]=1 for exactly one cycle; req_r_data = latched read data (0 for writes).
  - Update last_grant=grant; return to ARB_IDLE.
  - A new grant is possible in the following IDLE cycle.
- Latency, counted from the client's rw_valid to its ready, with zero-wait memory and no conflict:
  - read: 3 cycles (IDLE, MEM, RESP);
  - write: 3 cycles plus invalidate handshake time.
- Only one transaction is outstanding at any time. req_r_data is 0 outside ARB_RESP.
- Fairness: a continuously requesting client waits at most NREQ-1 other transactions.

Optional Feature:
SNOOP_SELF_INV_EN
- Defined: the target mask is all NREQ clients, including the writer. This is required when writers do not update their own cached line.
- Undefined: the target mask is all clients except the writer; with NREQ=2 this is exactly one client.

Decomposition:
- Package snoopy_bus_pkg: arb_stat_t enum {ARB_IDLE, ARB_MEM, ARB_INV, ARB_RESP}; default width constants.
- Sub-module rr_arbiter:
  - inputs: req[NREQ], advance strobe;
  - outputs: one-hot grant, grant index;
  - holds the last_grant pointer, updated on advance.

Test Plan:
1. Single read: client 0 reads 0x0000_1040, memory returns data 0x…A5 after 2 wait cycles -> mem_rw_addr=0x1040, mem_rw_we=0; req_rw_ready[0] pulses once with r_data=0x…A5; no inv_valid.
2. Contention: both clients read simultaneously after reset, then client 0 re-requests immediately -> grant order 0, 1, 0; client 1 is never skipped.
3. Write, self-invalidate disabled: client 1 writes 0x0000_2000 with mask 0xFFFF -> after mem_rw_ready, inv_valid=0b01 and inv_addr=0x2000. Client 0 acks after 3 cycles; req_rw_ready[1] pulses the cycle after the ack; inv_valid[0] is low the cycle after the ack.
4. Write, self-invalidate enabled: client 0 writes -> inv_valid=0b11; acks in separate cycles 1 and 4 -> ready only after both; each inv_valid line falls independently.
5. Reset asserted during ARB_INV -> next cycle all outputs 0 and pending cleared; the interrupted client gets no ready; client 0 has priority on the next request.
6. Stall: mem_rw_ready withheld for 20 cycles while the other client requests -> mem_* stable throughout; no second grant; no ready pulse.

Source files
------------

// File: rtl/snoopy_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snoopy_bus_pkg
// Description : Shared types and default widths for the snoopy bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package snoopy_bus_pkg;

    localparam int C_DEF_NREQ       = 2;
    localparam int C_DEF_ADDR_WIDTH = 32;
    localparam int C_DEF_WIDTH      = 128;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_MEM  = 2'd1,
        ARB_INV  = 2'd2,
        ARB_RESP = 2'd3
    } arb_stat_t;

    // Width of a client index; never zero even for a single client.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snoopy_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin requester selection. The pointer names the client
//               with top priority; it moves to one past the served client on
//               each advance strobe. Reset pointer 0 gives client 0 priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import snoopy_bus_pkg::*;
#(
    parameter int NREQ = C_DEF_NREQ,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_advance,
    input  logic [IW-1:0]   i_adv_idx,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_grant_idx,
    output logic            o_any
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] cand_idx;
    logic          found;
    int            cand;

    // Next pointer: one past the client just served, wrapping at NREQ.
    always_comb begin
        ptr_d = ptr_q;
        if (i_advance) begin
            if (int'(i_adv_idx) >= NREQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = IW'(int'(i_adv_idx) + 1);
            end
        end
    end

    // Pick the first requester at or after the pointer.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        found       = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IW'(cand);
            if (!found && i_req[cand_idx]) begin
                found       = 1'b1;
                o_grant_idx = cand_idx;
            end
        end
        if (found) begin
            o_grant[o_grant_idx] = 1'b1;
        end
        o_any = found;
    end

    // Priority pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/snoopy_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : snoopy_bus_arbiter
// Description : Shares one memory bus between NREQ cache clients. Requests
//               are served one at a time in round-robin order; each write is
//               followed by an invalidate broadcast, and the writer is only
//               acknowledged once every targeted cache has answered.
//               Build option SNOOP_SELF_INV_EN: the writer is invalidated too.
// Revision    : 1.0 - initial release
// ============================================================================
module snoopy_bus_arbiter
    import snoopy_bus_pkg::*;
#(
    parameter int NREQ       = C_DEF_NREQ,
    parameter int ADDR_WIDTH = C_DEF_ADDR_WIDTH,
    parameter int WIDTH      = C_DEF_WIDTH,
    parameter int MASKW      = WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_rw_valid,
    output logic [NREQ-1:0]        req_rw_ready,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_rw_addr,
    input  logic [NREQ-1:0]        req_rw_we,
    input  logic [NREQ*MASKW-1:0]  req_w_mask,
    input  logic [NREQ*WIDTH-1:0]  req_w_data,
    input  logic [NREQ-1:0]        req_w_ce,
    output logic [WIDTH-1:0]       req_r_data,
    output logic [NREQ-1:0]        req_inv_valid,
    output logic [ADDR_WIDTH-1:0]  req_inv_addr,
    input  logic [NREQ-1:0]        req_inv_ready,
    output logic                   mem_rw_valid,
    input  logic                   mem_rw_ready,
    output logic [ADDR_WIDTH-1:0]  mem_rw_addr,
    output logic                   mem_rw_we,
    output logic [MASKW-1:0]       mem_w_mask,
    output logic [WIDTH-1:0]       mem_w_data,
    output logic                   mem_w_ce,
    input  logic [WIDTH-1:0]       mem_r_data
);

    localparam int IW = idx_width(NREQ);

    arb_stat_t             state_q,     state_d;
    logic [IW-1:0]         grant_q,     grant_d;
    logic [NREQ-1:0]       grant_oh_q,  grant_oh_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic                  we_q,        we_d;
    logic [MASKW-1:0]      mask_q,      mask_d;
    logic [WIDTH-1:0]      wdata_q,     wdata_d;
    logic                  ce_q,        ce_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [WIDTH-1:0]      rdata_q,     rdata_d;
    logic [NREQ-1:0]       rdy_q,       rdy_d;
    logic [NREQ-1:0]       pending_q,   pending_d;

    logic [NREQ-1:0]       arb_grant;
    logic [IW-1:0]         arb_idx;
    logic                  arb_any;
    logic                  advance;
    logic [NREQ-1:0]       inv_target;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst         (rst),
        .i_req       (req_rw_valid),
        .i_advance   (advance),
        .i_adv_idx   (grant_q),
        .o_grant     (arb_grant),
        .o_grant_idx (arb_idx),
        .o_any       (arb_any)
    );

`ifdef SNOOP_SELF_INV_EN
    // Writer keeps a stale copy unless it is invalidated as well.
    assign inv_target = {NREQ{1'b1}};
`else
    // Writer updates its own line; only the other caches need invalidating.
    assign inv_target = ~grant_oh_q;
`endif

    // Next-state and next-output computation for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_oh_d  = grant_oh_q;
        addr_d      = addr_q;
        we_d        = we_q;
        mask_d      = mask_q;
        wdata_d     = wdata_q;
        ce_d        = ce_q;
        mem_valid_d = mem_valid_q;
        rdata_d     = rdata_q;
        rdy_d       = '0;
        pending_d   = pending_q;
        advance     = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (arb_any) begin
                    grant_d     = arb_idx;
                    grant_oh_d  = arb_grant;
                    addr_d      = req_rw_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    we_d        = req_rw_we[arb_idx];
                    mask_d      = req_w_mask[int'(arb_idx)*MASKW +: MASKW];
                    wdata_d     = req_w_data[int'(arb_idx)*WIDTH +: WIDTH];
                    ce_d        = req_w_ce[arb_idx];
                    mem_valid_d = 1'b1;
                    state_d     = ARB_MEM;
                end
            end
            ARB_MEM: begin
                if (mem_rw_ready) begin
                    mem_valid_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = mem_r_data;
                        rdy_d   = grant_oh_q;
                        state_d = ARB_RESP;
                    end else begin
                        rdata_d   = '0;
                        pending_d = inv_target;
                        if (inv_target != '0) begin
                            state_d = ARB_INV;
                        end else begin
                            rdy_d   = grant_oh_q;
                            state_d = ARB_RESP;
                        end
                    end
                end
            end
            ARB_INV: begin
                // Acks on clients that are not pending simply have no effect.
                pending_d = pending_q & ~req_inv_ready;
                if (pending_d == '0) begin
                    rdata_d = '0;
                    rdy_d   = grant_oh_q;
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                rdata_d = '0;
                advance = 1'b1;
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            grant_oh_q  <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            mask_q      <= '0;
            wdata_q     <= '0;
            ce_q        <= 1'b0;
            mem_valid_q <= 1'b0;
            rdata_q     <= '0;
            rdy_q       <= '0;
            pending_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_oh_q  <= grant_oh_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            mask_q      <= mask_d;
            wdata_q     <= wdata_d;
            ce_q        <= ce_d;
            mem_valid_q <= mem_valid_d;
            rdata_q     <= rdata_d;
            rdy_q       <= rdy_d;
            pending_q   <= pending_d;
        end
    end

    assign mem_rw_valid  = mem_valid_q;
    assign mem_rw_addr   = addr_q;
    assign mem_rw_we     = we_q;
    assign mem_w_mask    = mask_q;
    assign mem_w_data    = wdata_q;
    assign mem_w_ce      = ce_q;
    assign req_rw_ready  = rdy_q;
    assign req_r_data    = rdata_q;
    assign req_inv_valid = pending_q;
    assign req_inv_addr  = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_snoopy_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_snoopy_bus_arbiter
// Description : Self-checking bench for snoopy_bus_arbiter: directed scenarios
//               with literal expectations, then randomized traffic compared
//               every cycle against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snoopy_bus_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int W    = 128;
    localparam int MW   = W / 8;

`ifdef SNOOP_SELF_INV_EN
    localparam logic [1:0] C_INV_W1 = 2'b11;
    localparam logic [1:0] C_INV_W0 = 2'b11;
`else
    localparam logic [1:0] C_INV_W1 = 2'b01;
    localparam logic [1:0] C_INV_W0 = 2'b10;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_rw_valid, req_rw_ready, req_rw_we, req_w_ce;
    logic [NREQ*AW-1:0]   req_rw_addr;
    logic [NREQ*MW-1:0]   req_w_mask;
    logic [NREQ*W-1:0]    req_w_data;
    logic [W-1:0]         req_r_data;
    logic [NREQ-1:0]      req_inv_valid, req_inv_ready;
    logic [AW-1:0]        req_inv_addr;
    logic                 mem_rw_valid, mem_rw_ready, mem_rw_we, mem_w_ce;
    logic [AW-1:0]        mem_rw_addr;
    logic [MW-1:0]        mem_w_mask;
    logic [W-1:0]         mem_w_data, mem_r_data;

    snoopy_bus_arbiter #(
        .NREQ(NREQ), .ADDR_WIDTH(AW), .WIDTH(W), .MASKW(MW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_rw_valid(req_rw_valid), .req_rw_ready(req_rw_ready),
        .req_rw_addr(req_rw_addr), .req_rw_we(req_rw_we),
        .req_w_mask(req_w_mask), .req_w_data(req_w_data), .req_w_ce(req_w_ce),
        .req_r_data(req_r_data), .req_inv_valid(req_inv_valid),
        .req_inv_addr(req_inv_addr), .req_inv_ready(req_inv_ready),
        .mem_rw_valid(mem_rw_valid), .mem_rw_ready(mem_rw_ready),
        .mem_rw_addr(mem_rw_addr), .mem_rw_we(mem_rw_we),
        .mem_w_mask(mem_w_mask), .mem_w_data(mem_w_data), .mem_w_ce(mem_w_ce),
        .mem_r_data(mem_r_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model (transaction level) -----------------
    localparam int S_WAIT  = 0;  // no transaction owns the bus
    localparam int S_BUS   = 1;  // memory access in flight
    localparam int S_SNOOP = 2;  // waiting for invalidate acks
    localparam int S_DONE  = 3;  // completion being reported

    int          m_stage = S_WAIT;
    int          m_ptr   = 0;     // client with top priority
    int          m_cli   = 0;
    logic [AW-1:0] m_addr = '0;
    logic        m_we    = 1'b0;
    logic [MW-1:0] m_mask = '0;
    logic [W-1:0]  m_wdata = '0;
    logic        m_ce    = 1'b0;
    logic [NREQ-1:0] m_pend = '0;
    logic [W-1:0]  m_rd   = '0;
    int          waited[NREQ];

    function automatic logic [NREQ-1:0] targets(input int writer);
        logic [NREQ-1:0] t;
        t = '1;
`ifndef SNOOP_SELF_INV_EN
        t[writer] = 1'b0;
`endif
        return t;
    endfunction

    // Advance the model by one clock edge using the inputs applied this cycle.
    task automatic model_step();
        if (rst) begin
            m_stage = S_WAIT; m_ptr = 0; m_pend = '0; m_rd = '0;
            for (int i = 0; i < NREQ; i++) waited[i] = 0;
            m_addr = '0; m_we = 1'b0; m_mask = '0; m_wdata = '0; m_ce = 1'b0;
        end else begin
            case (m_stage)
                S_WAIT: begin
                    if (req_rw_valid != '0) begin
                        bit got;
                        got = 1'b0;
                        for (int k = 0; k < NREQ; k++) begin
                            int c;
                            c = (m_ptr + k) % NREQ;
                            if (!got && req_rw_valid[c]) begin
                                got     = 1'b1;
                                m_cli   = c;
                                m_addr  = req_rw_addr[c*AW +: AW];
                                m_we    = req_rw_we[c];
                                m_mask  = req_w_mask[c*MW +: MW];
                                m_wdata = req_w_data[c*W +: W];
                                m_ce    = req_w_ce[c];
                            end
                        end
                        m_stage = S_BUS;
                    end
                end
                S_BUS: begin
                    if (mem_rw_ready) begin
                        if (!m_we) begin
                            m_rd    = mem_r_data;
                            m_stage = S_DONE;
                        end else begin
                            m_rd    = '0;
                            m_pend  = targets(m_cli);
                            m_stage = (m_pend != '0) ? S_SNOOP : S_DONE;
                        end
                    end
                end
                S_SNOOP: begin
                    m_pend = m_pend & ~req_inv_ready;
                    if (m_pend == '0) m_stage = S_DONE;
                end
                default: begin
                    m_ptr   = (m_cli + 1) % NREQ;
                    m_stage = S_WAIT;
                end
            endcase
        end
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic compare_model();
        logic [NREQ-1:0] e_ready;
        e_ready = '0;
        if (m_stage == S_DONE) e_ready[m_cli] = 1'b1;
        chk("mem_rw_valid", W'(mem_rw_valid), W'(m_stage == S_BUS));
        if (m_stage == S_BUS) begin
            chk("mem_rw_addr", W'(mem_rw_addr), W'(m_addr));
            chk("mem_rw_we",   W'(mem_rw_we),   W'(m_we));
            chk("mem_w_mask",  W'(mem_w_mask),  W'(m_mask));
            chk("mem_w_data",  mem_w_data,      m_wdata);
            chk("mem_w_ce",    W'(mem_w_ce),    W'(m_ce));
        end
        chk("req_rw_ready", W'(req_rw_ready), W'(e_ready));
        chk("req_r_data", req_r_data, (m_stage == S_DONE && !m_we) ? m_rd : '0);
        chk("req_inv_valid", W'(req_inv_valid), (m_stage == S_SNOOP) ? W'(m_pend) : '0);
        if (m_stage == S_SNOOP) chk("req_inv_addr", W'(req_inv_addr), W'(m_addr));
        for (int i = 0; i < NREQ; i++) begin
            if (req_rw_ready[i]) begin
                chk("fairness", W'(waited[i] <= NREQ - 1), W'(1));
                waited[i] = 0;
            end else if (req_rw_valid[i] && req_rw_ready != '0) begin
                waited[i]++;
            end
        end
    endtask

    // One clock: compare at the falling edge, step the model at the rising
    // edge, then return slightly after it so callers can drive new inputs.
    task automatic cyc();
        @(negedge clk);
        if (!rst) compare_model();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [MW-1:0] m, input logic [W-1:0] d, input logic ce);
        req_rw_we[i]            = we;
        req_rw_addr[i*AW +: AW] = a;
        req_w_mask[i*MW +: MW]  = m;
        req_w_data[i*W +: W]    = d;
        req_w_ce[i]             = ce;
        req_rw_valid[i]         = 1'b1;
    endtask

    function automatic logic [W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- randomized traffic driver ----------------
    int gap[NREQ];
    int mwait = 0;

    task automatic drive_random();
        for (int i = 0; i < NREQ; i++) begin
            if (req_rw_valid[i]) begin
                if (req_rw_ready[i]) begin
                    req_rw_valid[i] = 1'b0;
                    gap[i] = int'($urandom_range(0, 3));
                end
            end else if (gap[i] > 0) begin
                gap[i]--;
            end else begin
                set_req(i, 1'($urandom_range(0, 1)), $urandom, MW'($urandom),
                        rnd_data(), 1'($urandom_range(0, 1)));
            end
        end
        if (mem_rw_ready) begin
            mem_rw_ready = 1'b0;
            mwait = int'($urandom_range(0, 3));
        end else if (mem_rw_valid) begin
            if (mwait > 0) begin
                mwait--;
            end else begin
                mem_rw_ready = 1'b1;
                mem_r_data   = rnd_data();
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_inv_ready[i]) begin
                req_inv_ready[i] = 1'b0;
            end else if (req_inv_valid[i]) begin
                req_inv_ready[i] = ($urandom_range(0, 2) == 0);
            end else if (req_inv_valid != '0) begin
                req_inv_ready[i] = ($urandom_range(0, 7) == 0);
            end
        end
    endtask

    initial begin
        int exp_ord[3];
        int got;
        int since_ready;
        logic [W-1:0] rdat;

        exp_ord = '{0, 1, 0};
        rst = 1'b1;
        req_rw_valid = '0; req_rw_we = '0; req_w_ce = '0;
        req_rw_addr = '0; req_w_mask = '0; req_w_data = '0;
        req_inv_ready = '0; mem_rw_ready = 1'b0; mem_r_data = '0;
        for (int i = 0; i < NREQ; i++) begin gap[i] = 0; waited[i] = 0; end
        @(posedge clk); model_step(); #2;
        cyc();
        // Reset state.
        chk("reset mem_rw_valid", W'(mem_rw_valid), '0);
        chk("reset req_rw_ready", W'(req_rw_ready), '0);
        chk("reset req_inv_valid", W'(req_inv_valid), '0);
        chk("reset req_r_data", req_r_data, '0);
        rst = 1'b0;
        cyc();

        // Single read with two memory wait cycles.
        rdat = 128'h0123_4567_89AB_CDEF_0011_2233_4455_66A5;
        set_req(0, 1'b0, 32'h0000_1040, '0, '0, 1'b0);
        cyc();
        chk("t1 mem_rw_valid", W'(mem_rw_valid), W'(1));
        chk("t1 mem_rw_addr", W'(mem_rw_addr), W'(32'h1040));
        chk("t1 mem_rw_we", W'(mem_rw_we), '0);
        cyc(); cyc();
        mem_rw_ready = 1'b1; mem_r_data = rdat;
        cyc();
        chk("t1 ready", W'(req_rw_ready), W'(2'b01));
        chk("t1 r_data", req_r_data, rdat);
        chk("t1 inv_valid", W'(req_inv_valid), '0);
        req_rw_valid = '0; mem_rw_ready = 1'b0;
        cyc();
        chk("t1 ready low", W'(req_rw_ready), '0);
        chk("t1 r_data zero", req_r_data, '0);

        // Contention right after reset: order 0, 1, 0.
        rst = 1'b1; cyc(); rst = 1'b0; cyc();
        set_req(0, 1'b0, 32'h0000_5000, '0, '0, 1'b0);
        set_req(1, 1'b0, 32'h0000_6000, '0, '0, 1'b0);
        mem_rw_ready = 1'b1; mem_r_data = rnd_data();
        for (int g = 0; g < 3; g++) begin
            got = -1;
            for (int k = 0; k < 12 && got < 0; k++) begin
                cyc();
                if (req_rw_ready != '0) got = req_rw_ready[1] ? 1 : 0;
            end
            chk("t2 grant order", W'(got), W'(exp_ord[g]));
            if (got == 1) req_rw_valid[1] = 1'b0;
        end
        req_rw_valid = '0; mem_rw_ready = 1'b0;
        cyc(); cyc();

        // Write from client 1 followed by an invalidate handshake.
        set_req(1, 1'b1, 32'h0000_2000, 16'hFFFF, rnd_data(), 1'b1);
        cyc();
        mem_rw_ready = 1'b1;
        cyc();
        mem_rw_ready = 1'b0;
        chk("t3 inv_valid", W'(req_inv_valid), W'(C_INV_W1));
        chk("t3 inv_addr", W'(req_inv_addr), W'(32'h2000));
        chk("t3 mem_rw_valid low", W'(mem_rw_valid), '0);
        cyc(); cyc(); cyc();
        chk("t3 no early ready", W'(req_rw_ready), '0);
        req_inv_ready = C_INV_W1;
        cyc();
        req_inv_ready = '0;
        chk("t3 ready", W'(req_rw_ready), W'(2'b10));
        chk("t3 inv_valid low", W'(req_inv_valid), '0);
        req_rw_valid = '0;
        cyc();

        // Memory stall while the other client is requesting.
        set_req(0, 1'b0, 32'h0000_3000, '0, '0, 1'b0);
        cyc();
        set_req(1, 1'b0, 32'h0000_4000, '0, '0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("t6 stall addr", W'(mem_rw_addr), W'(32'h3000));
            chk("t6 stall ready", W'(req_rw_ready), '0);
        end
        mem_rw_ready = 1'b1; mem_r_data = rnd_data();
        cyc();
        chk("t6 ready0", W'(req_rw_ready), W'(2'b01));
        req_rw_valid[0] = 1'b0; mem_rw_ready = 1'b0;
        cyc(); cyc();
        chk("t6 second grant", W'(mem_rw_addr), W'(32'h4000));
        mem_rw_ready = 1'b1;
        cyc();
        req_rw_valid[1] = 1'b0; mem_rw_ready = 1'b0;
        cyc();

        // Reset while invalidates are outstanding.
        set_req(0, 1'b1, 32'h0000_7000, 16'h00FF, rnd_data(), 1'b1);
        cyc();
        mem_rw_ready = 1'b1;
        cyc();
        mem_rw_ready = 1'b0;
        chk("t5 inv before reset", W'(req_inv_valid), W'(C_INV_W0));
        rst = 1'b1; req_rw_valid = '0;
        cyc();
        chk("t5 rst inv_valid", W'(req_inv_valid), '0);
        chk("t5 rst ready", W'(req_rw_ready), '0);
        chk("t5 rst mem_valid", W'(mem_rw_valid), '0);
        chk("t5 rst inv_addr", W'(req_inv_addr), '0);
        rst = 1'b0;
        cyc(); cyc();
        set_req(0, 1'b0, 32'h0000_8000, '0, '0, 1'b0);
        set_req(1, 1'b0, 32'h0000_9000, '0, '0, 1'b0);
        cyc();
        chk("t5 priority 0", W'(mem_rw_addr), W'(32'h8000));

        // Randomized traffic against the model.
        since_ready = 0;
        for (int n = 0; n < 4000; n++) begin
            drive_random();
            cyc();
            if (req_rw_ready != '0) since_ready = 0;
            else since_ready++;
            if (since_ready > 300) begin
                chk("progress timeout", W'(since_ready), '0);
                break;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
